lag_estimator: RTL
==================

# lag_estimator

Measures the latency, in clock cycles, of a configurable delay line (shift register) by matching a captured marker sequence from its input stream against its output stream. It sits beside the delay line: `ref_d` taps the delay-line input and `dly_d` taps its output. It reports the measured lag, or an error if no match is found. It is the checking end of the delay-line path, used for bring-up and for self-test of the programmed `shift_register_length`.

## Interface
- `DATA_WIDTH`, 16, width of `ref_d` and `dly_d`.
- `LAG_WIDTH`, 10, width of `lag`. The maximum measurable lag is MAX_LAG = 2**LAG_WIDTH-1.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request a measurement. Sampled only in IDLE or DONE.
- `ref_d` input DATA_WIDTH: delay-line input sample.
- `dly_d` input DATA_WIDTH: delay-line output sample.
- `busy` output 1: high in CAPTURE and SEARCH.
- `done` output 1: one-cycle pulse when a measurement ends, either with a match or on timeout.
- `locked` output 1: last measurement matched. Sticky until the next accepted `start`.
- `error` output 1: last measurement timed out. Sticky until the next accepted `start`.
- `lag` output LAG_WIDTH: measured lag. Held until the next match.
- `match_count` output 16: present only with `LAG_ESTIMATOR_MATCH_CNT_EN`.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, and the marker, window and counter registers are 0.
- FSM states: IDLE → CAPTURE → SEARCH → DONE.
  - From DONE, `start` returns to CAPTURE.
  - Otherwise DONE is held.
  - DONE differs from IDLE only in the retained status outputs.
- Edge k=0 is the edge at which `start` is accepted. Counter `k` increments at every edge thereafter.
- Marker capture:
  - At edges k=0..3, `ref_d` is stored as marker[k] (marker length is 4).
  - The FSM is in CAPTURE for edges k=0..2.
- Window:
  - From k=0, a 4-deep window shifts in `dly_d` every edge.
  - The compare uses win[k-3..k-1] from registers plus the current `dly_d` as the newest entry.
- Compare:
  - The compare is evaluated from k=3 onward, in SEARCH.
  - At k=3, marker[3] is taken directly from `ref_d`.
  - Match condition: all 4 window entries equal marker[0..3] in order, oldest entry against marker[0].
- On a match at edge k:
  - `lag` is set to k-3.
  - `locked` is set to 1, `done` pulses, and the FSM enters DONE.
  - A lag of 0 (combinational passthrough) is detected at k=3.
- Timeout: if there is no match at edge k = MAX_LAG+3, then `error` is set to 1, `done` pulses, `lag` is unchanged, and the FSM enters DONE.
- The first match wins. Later repeats of the marker are ignored.
- Accepting `start` clears `locked` and `error` at that same edge. `lag` keeps its old value.
- `start` while `busy` is ignored and has no side effect.
- Asserting `reset_n` low mid-measurement aborts immediately to the reset values. No `done` pulse is generated.
- `dly_d` that was sampled before k=0 is never part of a match.

## Timing
- `done`, `locked`, `error` and `lag` all update at the same edge, and all are registered.
- For a lag-L delay line, `done` is high in the cycle following edge k=L+3, i.e. L+4 cycles after the cycle in which `start` was high.
- Timeout `done` arrives MAX_LAG+4 cycles after `start`.
- `busy` rises at the edge after `start` is accepted and falls with the `done` edge.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `LAG_ESTIMATOR_MATCH_CNT_EN`.
- Defined:
  - `match_count` exists. It is reset to 0 and increments by 1 on each successful match.
  - It saturates at 16'hFFFF.
  - It is not cleared by `start`.
- Undefined: the `match_count` port and its counter are absent. All other behaviour is identical.

## Test plan
- Lag 70: delay line of length 70, fed a 7-bit triangle (0..127 then down). Pulse `start` → `done` 74 cycles later with `lag`=70, `locked`=1, `error`=0.
- Lag 0: `dly_d` tied to `ref_d`, `start` → `done` 4 cycles later, `lag`=0, `locked`=1.
- Timeout: `dly_d` held at 16'hFFFF, triangle on `ref_d`, `start` → `done` after 1027 cycles, `error`=1, `locked`=0, `lag` retains its previous value (70).
- `start` ignored: pulse `start` again at k=10 of a lag-70 run → the result is still `lag`=70 at the original `done` time, with exactly one `done` pulse.
- Reset mid-run: drop `reset_n` at k=20 → all outputs are 0 asynchronously, no `done` pulse. After release, a new `start` measures `lag`=70 correctly.
- Counter (macro defined): three successful lag-5 runs → `match_count`=3. A following timeout run leaves it at 3.

Source files
------------

// File: rtl/lag_estimator.sv
// lag_estimator: measures the latency of a delay line by capturing a
// 4-sample marker from the line input (ref_d) and searching for it in the
// line output (dly_d). Reports the lag in cycles, or an error on timeout.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          request a measurement (sampled in IDLE or DONE only)
//   ref_d, dly_d   delay-line input / output taps
//   busy           high while capturing or searching
//   done           one-cycle pulse at the end of a measurement
//   locked, error  sticky result of the last measurement
//   lag            last measured lag (held until the next match)
//   match_count    successful-match counter (only with
//                  LAG_ESTIMATOR_MATCH_CNT_EN defined)
//
// Optional feature macro: LAG_ESTIMATOR_MATCH_CNT_EN
module lag_estimator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LAG_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ref_d,
  input  logic [DATA_WIDTH-1:0] dly_d,
  output logic                  busy,
  output logic                  done,
  output logic                  locked,
  output logic                  error,
  output logic [LAG_WIDTH-1:0]  lag
`ifdef LAG_ESTIMATOR_MATCH_CNT_EN
  ,
  output logic [15:0]           match_count
`endif
);

  // Counter k must reach MAX_LAG+3, hence one extra bit over the lag width.
  localparam int unsigned KW      = LAG_WIDTH + 1;
  localparam int unsigned MAX_LAG = (2 ** LAG_WIDTH) - 1;
  localparam logic [KW-1:0] K_LAST_CAP = KW'(2);
  localparam logic [KW-1:0] K_M3       = KW'(3);
  localparam logic [KW-1:0] K_TIMEOUT  = KW'(MAX_LAG + 3);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q;
  logic [DATA_WIDTH-1:0] marker_q [4];
  logic [DATA_WIDTH-1:0] win_q    [3];   // win_q[0] oldest, win_q[2] newest

  logic                  accept_c;
  logic                  running_c;
  logic [DATA_WIDTH-1:0] m3_c;
  logic                  match_c;
  logic                  timeout_c;

  // Start is only honoured when idle or holding a previous result.
  assign accept_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign running_c = (state_q == ST_CAPTURE) || (state_q == ST_SEARCH);

  // marker[3] is being captured at k=3, so it is taken from ref_d that edge.
  assign m3_c = (k_q == K_M3) ? ref_d : marker_q[3];

  // Current dly_d is the newest window entry, enabling a zero-lag match.
  assign match_c = (state_q == ST_SEARCH)
                && (win_q[0] == marker_q[0])
                && (win_q[1] == marker_q[1])
                && (win_q[2] == marker_q[2])
                && (dly_d    == m3_c);

  assign timeout_c = (state_q == ST_SEARCH) && !match_c && (k_q == K_TIMEOUT);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_c) state_d = ST_CAPTURE;
      ST_CAPTURE: if (k_q == K_LAST_CAP) state_d = ST_SEARCH;
      ST_SEARCH:  if (match_c || timeout_c) state_d = ST_DONE;
      ST_DONE:    if (accept_c) state_d = ST_CAPTURE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Edge counter, marker capture and dly_d window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q <= '0;
      for (int i = 0; i < 4; i++) marker_q[i] <= '0;
      for (int i = 0; i < 3; i++) win_q[i]    <= '0;
    end else begin
      if (accept_c) begin
        k_q         <= KW'(1);
        marker_q[0] <= ref_d;
      end else if (running_c) begin
        k_q <= k_q + KW'(1);
        if (k_q <= K_M3) marker_q[k_q[1:0]] <= ref_d;
      end
      if (accept_c || running_c) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= dly_d;
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      locked <= 1'b0;
      error  <= 1'b0;
      lag    <= '0;
    end else begin
      busy <= (state_d == ST_CAPTURE) || (state_d == ST_SEARCH);
      done <= match_c || timeout_c;
      if (accept_c) begin
        locked <= 1'b0;
        error  <= 1'b0;
      end else begin
        if (match_c)   locked <= 1'b1;
        if (timeout_c) error  <= 1'b1;
      end
      if (match_c) lag <= LAG_WIDTH'(k_q - K_M3);
    end
  end

`ifdef LAG_ESTIMATOR_MATCH_CNT_EN
  // Saturating count of successful matches; survives start, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            match_count <= '0;
    else if (match_c && (match_count != 16'hFFFF)) match_count <= match_count + 16'd1;
  end
`endif

endmodule
